load_store_unit: RTL

Load/store unit placed directly upstream of `data_memory`. It accepts one RV32 load or store per transaction from the execute stage and converts the byte address to a word index. Because `data_memory` is word-wide with no byte enables, it performs read-modify-write for SB/SH. For loads it extracts and sign/zero-extends the addressed byte or halfword and returns it with a response pulse.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_lane_align.sv | 37 +++
 rtl/load_store_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and decode helper for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LD_ISSUE,
      LD_CAPT,
      ST_READ,
      ST_MERGE,
      ST_WRITE,
      RESP
   } lsu_state_t;

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we)
         return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
      return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data_memory bus of the load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_r, mem_w, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_r, mem_w, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane extraction with extension for loads, and lane merge for sub-word stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[8*addr_lo_i +: 8];
      half_sel = rdata_i[16*addr_lo_i[1] +: 16];
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_o = {24'b0, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'b0, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

   always_comb begin
      merge_data_o = rdata_i;
      case (funct3_i)
         F3_B:    merge_data_o[8*addr_lo_i +: 8]     = wdata_i[7:0];
         F3_H:    merge_data_o[16*addr_lo_i[1] +: 16] = wdata_i[15:0];
         default: merge_data_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of word-wide data_memory; read-modify-write for SB/SH.
// Optional alignment trapping: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned WORD_ADDR_W = 8
) (
   input logic   clk,
   input logic   rst_n,
   lsu_if.slave  bus
);

   lsu_state_t  state_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] wdata_q;
   logic        mem_r_q, mem_w_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic        resp_valid_q, resp_err_q;
   logic [31:0] resp_rdata_q;

   logic        illegal, misalign;
   logic [31:0] word_idx;
   logic [31:0] load_data, merge_data;

   assign illegal  = f3_illegal(bus.req_we, bus.req_funct3);
   assign word_idx = 32'(bus.req_addr[WORD_ADDR_W+1:2]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   lsu_lane_align u_align (
      .funct3_i     (f3_q),
      .addr_lo_i    (addr_lo_q),
      .rdata_i      (bus.mem_rdata),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .merge_data_o (merge_data)
   );

   // Strobes and response are registered on the transition into the state that owns them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_lo_q    <= '0;
         wdata_q      <= '0;
         mem_r_q      <= 1'b0;
         mem_w_q      <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         mem_r_q      <= 1'b0;
         mem_w_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.req_valid) begin
               we_q         <= bus.req_we;
               f3_q         <= bus.req_funct3;
               addr_lo_q    <= bus.req_addr[1:0];
               wdata_q      <= bus.req_wdata;
               mem_addr_q   <= word_idx;
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b0;
               if (illegal || misalign) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
               end else if (!bus.req_we) begin
                  state_q <= LD_ISSUE;
                  mem_r_q <= 1'b1;
               end else if (bus.req_funct3 == F3_W) begin
                  state_q     <= ST_WRITE;
                  mem_w_q     <= 1'b1;
                  mem_wdata_q <= bus.req_wdata;
               end else begin
                  state_q <= ST_READ;
                  mem_r_q <= 1'b1;
               end
            end
            LD_ISSUE: state_q <= LD_CAPT;
            LD_CAPT: begin
               resp_rdata_q <= load_data;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            ST_READ: state_q <= ST_MERGE;
            ST_MERGE: begin
               mem_wdata_q <= merge_data;
               mem_w_q     <= 1'b1;
               state_q     <= ST_WRITE;
            end
            ST_WRITE: begin
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               mem_addr_q   <= '0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_r      = mem_r_q;
   assign bus.mem_w      = mem_w_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule
